mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
Bus-master initiator for the 256x8 single-port data memory. It copies a block of Len bytes from SrcAddr to DstAddr, alternating one read cycle and one write cycle per byte, because the memory has one shared address port. It sits between the processor's control path and the data memory; the core muxes its own address, write-enable and write-data onto the memory while Busy is high.

Parameters:
W, 8, data width in bits; matches the memory entry width
A, 8, address width in bits; memory depth is 2**A

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
Start  input  1  request a copy; sampled only in IDLE
SrcAddr  input  A  first source address; latched on an accepted Start
DstAddr  input  A  first destination address; latched on an accepted Start
Len  input  A  byte count, 0..2**A-1; 0 = no-op
MemAddr  output  A  address driven to the memory
MemWrEn  output  1  write enable to the memory
MemWrData  output  W  write data to the memory
MemRdData  input  W  combinational read data from the memory at MemAddr
Busy  output  1  copy in progress (states RD, WR, DONE)
Done  output  1  one-cycle pulse when the copy completes

Behaviour:
- Reset (Reset=0, asynchronous) forces:
  - state IDLE;
  - MemAddr=0, MemWrEn=0, MemWrData=0, Busy=0, Done=0;
  - internal src/dst pointers, remaining count and data buffer all 0.
- Reset mid-copy abandons the transfer at once. Any in-flight write is dropped; no Done pulse is produced.
- FSM has four states: IDLE, RD, WR, DONE. All outputs are registered.
- IDLE:
  - Start=1 at a clock edge latches SrcAddr, DstAddr and Len.
  - Len!=0 -> RD; Len==0 -> DONE.
- RD:
  - MemAddr = src pointer, MemWrEn=0.
  - At the edge, MemRdData is captured into the buffer and the state goes to WR.
- WR:
  - MemAddr = dst pointer, MemWrData = buffer, MemWrEn=1 for exactly this cycle.
  - At the edge: src and dst step by 1, remaining count decrements.
  - remaining==0 after decrement -> DONE, else -> RD.
- DONE: Done=1 and Busy=1 for one cycle, then IDLE (Done=0, Busy=0).
- Latency: Done is high in cycle 2*Len+1 after the Start edge (cycle 1 = first RD). Len=0 gives Done in cycle 1.
- Start while Busy is ignored. Latched operands are unaffected by input changes during a copy.
- Address arithmetic is modulo 2**A: pointer 0xFF+1 = 0x00 for both src and dst. There is no error on wrap.
- Writes happen only in WR. MemWrEn is never high in IDLE, RD or DONE.
- Overlap without the optional feature: copy is always ascending. If DstAddr is in (SrcAddr, SrcAddr+Len), the source pattern of length DstAddr-SrcAddr replicates; this is defined, deterministic behaviour.

Optional Feature:
- Macro: MEM_COPY_OVERLAP_EN.
- Defined:
  - At Start, the block computes in A+1-bit arithmetic whether DstAddr > SrcAddr and DstAddr < SrcAddr+Len (no wrap).
  - If true, pointers load SrcAddr+Len-1 and DstAddr+Len-1 and decrement each WR. Result matches a memmove.
  - Otherwise the copy is ascending.
  - Cycle count is unchanged.
- Undefined: always ascending, as in Behaviour. The comparison logic is absent.

Test Plan:
- Reset=0 then release; preload mem[0x10..0x13]=A1,B2,C3,D4; Start with Src=0x10, Dst=0x40, Len=4 -> MemWrEn pulses at cycles 2,4,6,8 with addr 0x40..0x43 and data A1..D4; Done in cycle 9; mem[0x40..0x43]=A1,B2,C3,D4.
- Start with Len=0 -> Busy and Done high in cycle 1 only; MemWrEn never asserted; memory unchanged.
- Src=0xFE, Dst=0x80, Len=4 -> reads at 0xFE,0xFF,0x00,0x01; writes at 0x80..0x83 with matching data.
- During a Len=3 copy, pulse Start with new operands at cycle 2 -> ignored; exactly 3 writes to the original destination; a single Done.
- Preload mem[0x20..0x23]=01,02,03,04; Src=0x20, Dst=0x22, Len=4 -> with MEM_COPY_OVERLAP_EN, mem[0x22..0x25]=01,02,03,04; without it, mem[0x22..0x25]=01,02,01,02.
- Len=8 copy, assert Reset=0 mid-WR at cycle 6 -> MemWrEn drops without waiting for a clock edge; only 2 destination bytes written; no Done; after release, a new copy runs correctly.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus-master block copier for a single-port data memory. It copies Len bytes
//   from SrcAddr to DstAddr. Each byte takes one read cycle (RD) and then one
//   write cycle (WR), because the memory has a single shared address port.
//   Every output is registered, so the value driven in a cycle is derived from
//   that cycle's state.
//
//   Optional build macro MEM_COPY_OVERLAP_EN: when it is defined, a
//   destination that overlaps the tail of the source is copied in descending
//   order, which gives memmove semantics. When it is undefined, the copy is
//   always ascending.
//
// Ports
//   Clk        rising-edge clock
//   Reset      asynchronous active-low reset
//   Start      copy request, accepted only while idle
//   SrcAddr    first source address, latched on an accepted Start
//   DstAddr    first destination address, latched on an accepted Start
//   Len        byte count (0 = no-op), latched on an accepted Start
//   MemAddr    memory address (source in RD, destination in WR, else 0)
//   MemWrEn    memory write enable, high only in WR
//   MemWrData  memory write data (buffered byte in WR, else 0)
//   MemRdData  combinational memory read data at MemAddr
//   Busy       high in RD, WR and DONE
//   Done       one-cycle completion pulse
module mem_copy_engine #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Len,
    output logic [A-1:0] MemAddr,
    output logic         MemWrEn,
    output logic [W-1:0] MemWrData,
    input  logic [W-1:0] MemRdData,
    output logic         Busy,
    output logic         Done
);

    localparam logic [A-1:0] ONE = A'(1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

    state_e       state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] cnt_q, cnt_d;
    logic [W-1:0] buf_q, buf_d;
    logic [A-1:0] addr_q, addr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         wren_q, wren_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [A-1:0] step;

`ifdef MEM_COPY_OVERLAP_EN
    logic desc_q, desc_d;
    logic overlap;

    // The extra top bit keeps SrcAddr+Len from wrapping, so a destination
    // that only overlaps "around" address 0 is not treated as overlapping.
    assign overlap = ({1'b0, DstAddr} > {1'b0, SrcAddr}) &&
                     ({1'b0, DstAddr} < ({1'b0, SrcAddr} + {1'b0, Len}));
    // Adding all-ones is a decrement in modulo-2**A arithmetic.
    assign step    = desc_q ? {A{1'b1}} : ONE;
`else
    assign step    = ONE;
`endif

    // NOTE: every variable gets a default before the case statement, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
`ifdef MEM_COPY_OVERLAP_EN
        desc_d  = desc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cnt_d   = Len;
`ifdef MEM_COPY_OVERLAP_EN
                    desc_d  = overlap;
                    src_d   = overlap ? (SrcAddr + Len - ONE) : SrcAddr;
                    dst_d   = overlap ? (DstAddr + Len - ONE) : DstAddr;
`else
                    src_d   = SrcAddr;
                    dst_d   = DstAddr;
`endif
                    state_d = (Len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                buf_d   = MemRdData;
                state_d = S_WR;
            end
            S_WR: begin
                src_d   = src_q + step;
                dst_d   = dst_q + step;
                cnt_d   = cnt_q - ONE;
                state_d = (cnt_d == '0) ? S_DONE : S_RD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The outputs are registered from the next state, so they line up
        // with the state they describe, with no combinational path to a port.
        addr_d  = '0;
        wdata_d = '0;
        wren_d  = 1'b0;
        case (state_d)
            S_RD: addr_d = src_d;
            S_WR: begin
                addr_d  = dst_d;
                wdata_d = buf_d;
                wren_d  = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // NOTE: state elements use non-blocking assignments, so every register
    // updates from the values held before the edge, whatever the statement
    // order. The byte buffer is a single register, so resetting it is cheap
    // and keeps it deterministic.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_COPY_OVERLAP_EN
            desc_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MEM_COPY_OVERLAP_EN
            desc_q  <= desc_d;
`endif
        end
    end

    assign MemAddr   = addr_q;
    assign MemWrEn   = wren_q;
    assign MemWrData = wdata_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine. It models a 256x8 memory with combinational
// read and clocked write. The stimulus pushes the expected writes and Done
// pulses (address, data, cycle) into queues. A monitor on the falling edge
// pops each queue entry and compares it whenever the DUT writes or pulses Done.
module tb_mem_copy_engine;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] SrcAddr = '0;
    logic [7:0] DstAddr = '0;
    logic [7:0] Len = '0;
    logic [7:0] MemAddr;
    logic       MemWrEn;
    logic [7:0] MemWrData;
    logic [7:0] MemRdData;
    logic       Busy;
    logic       Done;

    mem_copy_engine #(.W(8), .A(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .SrcAddr   (SrcAddr),
        .DstAddr   (DstAddr),
        .Len       (Len),
        .MemAddr   (MemAddr),
        .MemWrEn   (MemWrEn),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [256];
    assign MemRdData = mem[MemAddr];
    always @(posedge Clk) if (MemWrEn) mem[MemAddr] <= MemWrData;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  n_checks = 0;
    int  n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic flag_fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected no event", name, act);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input int c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_wr.push_back(e);
    endtask

    // Monitor: compares every observed write or Done pulse against the queues.
    always @(negedge Clk) begin
        if (Reset) begin
            if (MemWrEn) begin
                if (exp_wr.size() == 0) flag_fail("spurious_write_addr", 32'(MemAddr));
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(MemAddr), 32'(e.addr));
                    check("wr_data", 32'(MemWrData), 32'(e.data));
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (Done) begin
                if (exp_done.size() == 0) flag_fail("spurious_done_cycle", cyc);
                else begin
                    int dc;
                    dc = exp_done.pop_front();
                    check("done_cycle", cyc, dc);
                    check("busy_with_done", 32'(Busy), 32'd1);
                end
            end
        end
    end

    // Sets up a copy at a falling edge. The caller then pushes the expected
    // events and calls release_start(). Cycle k of the copy has cyc == c + k.
    task automatic begin_copy(input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] l, output int c);
        @(negedge Clk);
        c       = cyc;
        SrcAddr = s;
        DstAddr = d;
        Len     = l;
        Start   = 1'b1;
    endtask

    task automatic release_start();
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Bounded wait for the copy to finish, then confirm it has finished.
    task automatic finish_copy(input string name, input int len);
        repeat (2 * len + 3) @(negedge Clk);
        check({name, "_idle"}, 32'(Busy), 32'd0);
        check({name, "_wr_queue_empty"}, exp_wr.size(), 0);
        check({name, "_done_queue_empty"}, exp_done.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [7:0] t1 [4];
        logic [7:0] t3 [4];
        logic [7:0] t5 [4];

        t1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        t3 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        repeat (2) @(negedge Clk);
        check("rst_addr", 32'(MemAddr), 32'd0);
        check("rst_wren", 32'(MemWrEn), 32'd0);
        check("rst_wdata", 32'(MemWrData), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        Reset = 1'b1;

        // T1: basic copy, 0x10 -> 0x40, Len 4
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = t1[i];
        begin_copy(8'h10, 8'h40, 8'd4, c);
        for (int i = 0; i < 4; i++) push_wr(8'(8'h40 + i), t1[i], c + 2 * (i + 1));
        exp_done.push_back(c + 9);
        release_start();
        check("t1_busy_c1", 32'(Busy), 32'd1);
        check("t1_addr_c1", 32'(MemAddr), 32'h10);
        finish_copy("t1", 4);
        for (int i = 0; i < 4; i++) check("t1_mem", 32'(mem[8'h40 + i]), 32'(t1[i]));

        // T2: Len 0, Done in cycle 1 and no writes
        begin_copy(8'h10, 8'h90, 8'd0, c);
        exp_done.push_back(c + 1);
        release_start();
        check("t2_busy_c1", 32'(Busy), 32'd1);
        @(negedge Clk);
        check("t2_busy_c2", 32'(Busy), 32'd0);
        check("t2_done_c2", 32'(Done), 32'd0);
        finish_copy("t2", 0);
        check("t2_mem_untouched", 32'(mem[8'h90]), 32'h00);

        // T3: source wraps 0xFF -> 0x00
        mem[8'hFE] = t3[0]; mem[8'hFF] = t3[1]; mem[8'h00] = t3[2]; mem[8'h01] = t3[3];
        begin_copy(8'hFE, 8'h80, 8'd4, c);
        for (int i = 0; i < 4; i++) push_wr(8'(8'h80 + i), t3[i], c + 2 * (i + 1));
        exp_done.push_back(c + 9);
        release_start();
        finish_copy("t3", 4);

        // T4: a Start during a copy is ignored
        begin_copy(8'h10, 8'hA0, 8'd3, c);
        for (int i = 0; i < 3; i++) push_wr(8'(8'hA0 + i), t1[i], c + 2 * (i + 1));
        exp_done.push_back(c + 7);
        release_start();
        @(negedge Clk);
        SrcAddr = 8'h20; DstAddr = 8'hB0; Len = 8'd5; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        finish_copy("t4", 3);
        check("t4_new_dst_untouched", 32'(mem[8'hB0]), 32'h00);

        // T5: overlapping copy 0x20 -> 0x22, Len 4
        for (int i = 0; i < 4; i++) mem[8'h20 + i] = 8'(i + 1);
        begin_copy(8'h20, 8'h22, 8'd4, c);
`ifdef MEM_COPY_OVERLAP_EN
        t5 = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) push_wr(8'(8'h25 - i), t5[3 - i], c + 2 * (i + 1));
`else
        t5 = '{8'h01, 8'h02, 8'h01, 8'h02};
        for (int i = 0; i < 4; i++) push_wr(8'(8'h22 + i), t5[i], c + 2 * (i + 1));
`endif
        exp_done.push_back(c + 9);
        release_start();
        finish_copy("t5", 4);
        for (int i = 0; i < 4; i++) check("t5_mem", 32'(mem[8'h22 + i]), 32'(t5[i]));

        // T6: reset in the WR of cycle 6, which drops the third write and Done
        for (int i = 0; i < 8; i++) mem[8'h50 + i] = 8'(8'h61 + i);
        begin_copy(8'h50, 8'h60, 8'd8, c);
        push_wr(8'h60, 8'h61, c + 2);
        push_wr(8'h61, 8'h62, c + 4);
        repeat (6) @(posedge Clk);
        #1;
        check("t6_wren_before_rst", 32'(MemWrEn), 32'd1);
        Start = 1'b0;
        Reset = 1'b0;
        #1;
        check("t6_wren_async", 32'(MemWrEn), 32'd0);
        check("t6_busy_async", 32'(Busy), 32'd0);
        check("t6_addr_async", 32'(MemAddr), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("t6_idle_after_rst", 32'(Busy), 32'd0);
        check("t6_wr_queue_empty", exp_wr.size(), 0);
        check("t6_mem0", 32'(mem[8'h60]), 32'h61);
        check("t6_mem1", 32'(mem[8'h61]), 32'h62);
        check("t6_mem2_dropped", 32'(mem[8'h62]), 32'h00);
        begin_copy(8'h50, 8'h70, 8'd2, c);
        push_wr(8'h70, 8'h61, c + 2);
        push_wr(8'h71, 8'h62, c + 4);
        exp_done.push_back(c + 5);
        release_start();
        finish_copy("t6_recover", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
